// File: rtl/pipe_stage_fwd_reg_pkg.sv
// Shared definitions for the generic pipeline stage register.
//   - Default widths for operands, payload, control word and stall counter.
//   - Control word field offsets, so hazard/trace logic decodes out_ctrl consistently.
//   - CTRL_BUBBLE: the all-zero control word (no rf/ram write, no branch).
//   - slot_op_e: per-cycle action applied to one pipe slot.
package pipe_stage_fwd_reg_pkg;

   localparam int unsigned XLEN_DEF    = 32;
   localparam int unsigned NUM_OPS_DEF = 2;
   localparam int unsigned DATA_W_DEF  = 101;
   localparam int unsigned CTRL_W_DEF  = 13;
   localparam int unsigned CNT_W_DEF   = 16;

   // Control word layout (LSB offsets / widths)
   localparam int unsigned CTRL_RF_WSEL_LSB = 0;   // 2 bits
   localparam int unsigned CTRL_BRANCH_LSB  = 2;   // 3 bits
   localparam int unsigned CTRL_RF_WE_BIT   = 5;   // 1 bit
   localparam int unsigned CTRL_ALU_OP_LSB  = 6;   // 4 bits
   localparam int unsigned CTRL_ALUB_SEL_LSB = 10; // 2 bits
   localparam int unsigned CTRL_RAM_WE_BIT  = 12;  // 1 bit

   localparam logic [CTRL_W_DEF-1:0] CTRL_BUBBLE = '0;

   typedef enum logic [1:0] {
      SLOT_HOLD  = 2'd0,  // keep contents; operand refresh allowed
      SLOT_LOAD  = 2'd1,  // capture a new beat
      SLOT_CLEAR = 2'd2   // empty the slot and zero it (bubble)
   } slot_op_e;

endpackage

// File: rtl/pipe_stage_fwd_reg_slot.sv
// One pipeline entry: valid flag, payload, control word and operands.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   op              action this edge (hold / load / clear)
//   refresh         entry is stalled; allows upd_en/upd_data refresh on hold
//   ld_data/ctrl    beat payload and control to load
//   ld_ops          beat operands to load
//   ld_sel/ld_alt   per-op capture mux: ld_sel[i] picks ld_alt[i] over ld_ops[i]
//   upd_en/upd_data per-op refresh of held operands
//   valid/data/ctrl/ops  registered entry contents
module pipe_stage_fwd_reg_slot
   import pipe_stage_fwd_reg_pkg::*;
#(
   parameter int unsigned XLEN    = XLEN_DEF,
   parameter int unsigned NUM_OPS = NUM_OPS_DEF,
   parameter int unsigned DATA_W  = DATA_W_DEF,
   parameter int unsigned CTRL_W  = CTRL_W_DEF
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  slot_op_e                op,
   input  logic                    refresh,
   input  logic [DATA_W-1:0]       ld_data,
   input  logic [CTRL_W-1:0]       ld_ctrl,
   input  logic [NUM_OPS*XLEN-1:0] ld_ops,
   input  logic [NUM_OPS-1:0]      ld_sel,
   input  logic [NUM_OPS*XLEN-1:0] ld_alt,
   input  logic [NUM_OPS-1:0]      upd_en,
   input  logic [NUM_OPS*XLEN-1:0] upd_data,
   output logic                    valid,
   output logic [DATA_W-1:0]       data,
   output logic [CTRL_W-1:0]       ctrl,
   output logic [NUM_OPS*XLEN-1:0] ops
);

   logic [NUM_OPS*XLEN-1:0] cap_ops;
   logic [NUM_OPS*XLEN-1:0] upd_ops;

   always_comb begin
      cap_ops = '0;
      upd_ops = '0;
      for (int unsigned i = 0; i < NUM_OPS; i++) begin
         cap_ops[i*XLEN +: XLEN] = ld_sel[i] ? ld_alt[i*XLEN +: XLEN]
                                             : ld_ops[i*XLEN +: XLEN];
         upd_ops[i*XLEN +: XLEN] = upd_en[i] ? upd_data[i*XLEN +: XLEN]
                                             : ops[i*XLEN +: XLEN];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= 1'b0;
         data  <= '0;
         ctrl  <= CTRL_W'(CTRL_BUBBLE);
         ops   <= '0;
      end else begin
         case (op)
            SLOT_CLEAR: begin
               // Zeroing ctrl on every empty keeps "invalid implies bubble"
               valid <= 1'b0;
               data  <= '0;
               ctrl  <= CTRL_W'(CTRL_BUBBLE);
               ops   <= '0;
            end
            SLOT_LOAD: begin
               valid <= 1'b1;
               data  <= ld_data;
               ctrl  <= ld_ctrl;
               ops   <= cap_ops;
            end
            default: begin
               if (refresh && valid) ops <= upd_ops;
            end
         endcase
      end
   end

endmodule

// File: rtl/pipe_stage_fwd_reg.sv
// Generic pipeline stage register with valid/ready handshake, flush-to-bubble,
// per-operand forwarding on capture, held-operand refresh while stalled, an
// optional skid entry (SKID=1) giving a registered in_ready, and a saturating
// stall counter.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid/in_ready          upstream handshake
//   in_data/in_ctrl/in_ops     incoming beat (op i at [i*XLEN +: XLEN])
//   fwd_en/fwd_data            per-op forwarded value used on capture
//   hold_upd_en/hold_upd_data  per-op refresh of the stalled output entry
//   flush                      kill held entries and the incoming beat
//   out_valid/out_ready        downstream handshake
//   out_data/out_ctrl/out_ops  registered output entry
//   stall_cnt                  saturating count of stalled output cycles
module pipe_stage_fwd_reg
   import pipe_stage_fwd_reg_pkg::*;
#(
   parameter int unsigned XLEN    = XLEN_DEF,
   parameter int unsigned NUM_OPS = NUM_OPS_DEF,
   parameter int unsigned DATA_W  = DATA_W_DEF,
   parameter int unsigned CTRL_W  = CTRL_W_DEF,
   parameter int unsigned SKID    = 0,
   parameter int unsigned CNT_W   = CNT_W_DEF
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [DATA_W-1:0]       in_data,
   input  logic [CTRL_W-1:0]       in_ctrl,
   input  logic [NUM_OPS*XLEN-1:0] in_ops,
   input  logic [NUM_OPS-1:0]      fwd_en,
   input  logic [NUM_OPS*XLEN-1:0] fwd_data,
   input  logic [NUM_OPS-1:0]      hold_upd_en,
   input  logic [NUM_OPS*XLEN-1:0] hold_upd_data,
   input  logic                    flush,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [DATA_W-1:0]       out_data,
   output logic [CTRL_W-1:0]       out_ctrl,
   output logic [NUM_OPS*XLEN-1:0] out_ops,
   output logic [CNT_W-1:0]        stall_cnt
);

   logic                    accept;
   slot_op_e                out_op;
   logic [DATA_W-1:0]       out_ld_data;
   logic [CTRL_W-1:0]       out_ld_ctrl;
   logic [NUM_OPS*XLEN-1:0] out_ld_ops;
   logic [NUM_OPS-1:0]      out_ld_sel;

   assign accept = in_valid & in_ready;

   generate
      if (SKID != 0) begin : g_skid
         logic                    skid_valid;
         logic [DATA_W-1:0]       skid_data;
         logic [CTRL_W-1:0]       skid_ctrl;
         logic [NUM_OPS*XLEN-1:0] skid_ops;
         slot_op_e                skid_op;

         // Registered ready: the skid is only ever filled while the output is
         // stalled, so it absorbs the beat accepted in the cycle ready drops.
         assign in_ready = ~skid_valid;

         always_comb begin
            out_op      = SLOT_HOLD;
            skid_op     = SLOT_HOLD;
            out_ld_data = in_data;
            out_ld_ctrl = in_ctrl;
            out_ld_ops  = in_ops;
            out_ld_sel  = fwd_en;
            if (flush) begin
               out_op  = SLOT_CLEAR;
               skid_op = SLOT_CLEAR;
            end else if (skid_valid) begin
               // Skid full implies out full; nothing is accepted this cycle.
               if (out_ready) begin
                  out_op      = SLOT_LOAD;
                  out_ld_data = skid_data;
                  out_ld_ctrl = skid_ctrl;
                  out_ld_ops  = skid_ops;
                  out_ld_sel  = '0;  // skid operands were already forwarded
                  skid_op     = SLOT_CLEAR;
               end
            end else if (accept) begin
               if (!out_valid || out_ready) out_op  = SLOT_LOAD;
               else                         skid_op = SLOT_LOAD;
            end else if (out_valid && out_ready) begin
               out_op = SLOT_CLEAR;
            end
         end

         pipe_stage_fwd_reg_slot #(
            .XLEN    (XLEN),
            .NUM_OPS (NUM_OPS),
            .DATA_W  (DATA_W),
            .CTRL_W  (CTRL_W)
         ) u_skid (
            .clk      (clk),
            .rst_n    (rst_n),
            .op       (skid_op),
            .refresh  (1'b1),
            .ld_data  (in_data),
            .ld_ctrl  (in_ctrl),
            .ld_ops   (in_ops),
            .ld_sel   (fwd_en),
            .ld_alt   (fwd_data),
            .upd_en   (fwd_en),
            .upd_data (fwd_data),
            .valid    (skid_valid),
            .data     (skid_data),
            .ctrl     (skid_ctrl),
            .ops      (skid_ops)
         );
      end else begin : g_noskid
         assign in_ready = out_ready | ~out_valid;

         always_comb begin
            out_op      = SLOT_HOLD;
            out_ld_data = in_data;
            out_ld_ctrl = in_ctrl;
            out_ld_ops  = in_ops;
            out_ld_sel  = fwd_en;
            if (flush)                        out_op = SLOT_CLEAR;
            else if (accept)                  out_op = SLOT_LOAD;
            else if (out_valid && out_ready)  out_op = SLOT_CLEAR;
         end
      end
   endgenerate

   pipe_stage_fwd_reg_slot #(
      .XLEN    (XLEN),
      .NUM_OPS (NUM_OPS),
      .DATA_W  (DATA_W),
      .CTRL_W  (CTRL_W)
   ) u_out (
      .clk      (clk),
      .rst_n    (rst_n),
      .op       (out_op),
      .refresh  (~out_ready),
      .ld_data  (out_ld_data),
      .ld_ctrl  (out_ld_ctrl),
      .ld_ops   (out_ld_ops),
      .ld_sel   (out_ld_sel),
      .ld_alt   (fwd_data),
      .upd_en   (hold_upd_en),
      .upd_data (hold_upd_data),
      .valid    (out_valid),
      .data     (out_data),
      .ctrl     (out_ctrl),
      .ops      (out_ops)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
      end else if (out_valid && !out_ready && !flush && (stall_cnt != '1)) begin
         stall_cnt <= stall_cnt + 1'b1;
      end
   end

endmodule
